// File: rtl/tl_dcache_stage.sv
// Tag-lookup stage: direct-mapped, write-through / no-write-allocate data cache with a
// single-beat line-fill port, plus the TL->WB pipeline latch.
module tl_dcache_stage #(
  parameter int LINES = 16
) (
  input  logic         clk_i,
  input  logic         rsn_i,
  input  logic         kill_i,
  input  logic         tl_cache_enable_i,
  input  logic [31:0]  tl_cache_addr_i,
  input  logic [4:0]   tl_write_addr_i,
  input  logic         tl_int_write_enable_i,
  input  logic [31:0]  tl_store_data_i,
  input  logic [31:0]  tl_instruction_i,
  input  logic [31:0]  tl_pc_i,
  output logic         stall_core_o,
  output logic [31:0]  wb_data_o,
  output logic [4:0]   wb_write_addr_o,
  output logic         wb_int_write_enable_o,
  output logic [31:0]  wb_instruction_o,
  output logic [31:0]  wb_pc_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [31:0]  mem_wdata_o,
  output logic [3:0]   mem_wstrb_o,
  input  logic         mem_ack_i,
  input  logic [127:0] mem_rdata_i
);

  localparam int IDX = $clog2(LINES);
  localparam int TAG = 28 - IDX;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  function automatic logic [31:0] load_format(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_format = {{24{b[7]}}, b};
      3'b001:  load_format = {{16{h[15]}}, h};
      3'b010:  load_format = word;
      3'b100:  load_format = {24'd0, b};
      3'b101:  load_format = {16'd0, h};
      default: load_format = word;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  store_strobe = 4'b0001 << off;
      3'b001:  store_strobe = 4'b0011 << {off[1], 1'b0};
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  store_lanes = {4{d[7:0]}};
      3'b001:  store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [LINES-1:0] valid_r;
  logic [TAG-1:0]   tag_r  [LINES];
  logic [127:0]     data_r [LINES];

  logic [IDX-1:0]   idx_s;
  logic [TAG-1:0]   tag_s;
  logic [2:0]       funct3_s;
  logic             is_load_s;
  logic             is_store_s;
  logic             hit_s;
  logic [31:0]      word_s;
  logic             stall_s;
  logic             issue_s;
  logic             fill_s;
  logic             merge_s;

  logic             mem_req_r;
  logic             mem_we_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic [3:0]       mem_wstrb_r;

  logic [31:0]      wb_data_r;
  logic [4:0]       wb_write_addr_r;
  logic             wb_we_r;
  logic [31:0]      wb_instruction_r;
  logic [31:0]      wb_pc_r;

  assign idx_s      = tl_cache_addr_i[IDX+3:4];
  assign tag_s      = tl_cache_addr_i[31:IDX+4];
  assign funct3_s   = tl_instruction_i[14:12];
  assign is_load_s  = tl_cache_enable_i && (tl_instruction_i[6:0] == OP_LOAD);
  assign is_store_s = tl_cache_enable_i && (tl_instruction_i[6:0] == OP_STORE);
  assign hit_s      = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign word_s     = data_r[idx_s][{tl_cache_addr_i[3:2], 5'b00000} +: 32];
  assign fill_s     = (state_r == ST_FILL) && mem_ack_i;
  assign merge_s    = (state_r == ST_WRITE) && mem_ack_i && hit_s;

  // Next-state, stall and request-issue decode.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    issue_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!kill_i && (is_store_s || (is_load_s && !hit_s))) begin
          stall_s     = 1'b1;
          issue_s     = 1'b1;
          state_nxt_s = is_store_s ? ST_WRITE : ST_FILL;
        end else begin
          stall_s     = 1'b0;
        end
      end
      ST_FILL: begin
        stall_s = 1'b1;
        if (mem_ack_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_WRITE: begin
        stall_s = 1'b1;
        if (mem_ack_i) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Gated so every output reads 0 while reset is held, even with a miss presented.
  assign stall_core_o = stall_s & rsn_i;

  // FSM state and line-valid bits.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_r <= ST_IDLE;
      valid_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (fill_s) begin
        valid_r[idx_s] <= 1'b1;
      end
    end
  end

  // Tag/data arrays: line install on fill ack, byte merge on a store-hit ack.
  always_ff @(posedge clk_i) begin
    if (fill_s) begin
      tag_r[idx_s]  <= tag_s;
      data_r[idx_s] <= mem_rdata_i;
    end else if (merge_s) begin
      data_r[idx_s][{tl_cache_addr_i[3:2], 5'b00000} +: 32] <= merge_bytes(word_s, mem_wdata_r, mem_wstrb_r);
    end
  end

  // Memory request registers: captured at issue, held until the ack edge.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_wstrb_r <= 4'd0;
    end else if (issue_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= is_store_s;
      mem_addr_r  <= is_store_s ? {tl_cache_addr_i[31:2], 2'b00} : {tl_cache_addr_i[31:4], 4'b0000};
      mem_wdata_r <= store_lanes(funct3_s, tl_store_data_i);
      mem_wstrb_r <= is_store_s ? store_strobe(funct3_s, tl_cache_addr_i[1:0]) : 4'b0000;
    end else if (mem_ack_i && ((state_r == ST_FILL) || (state_r == ST_WRITE))) begin
      mem_req_r   <= 1'b0;
    end
  end

  // TL->WB latch; a stall or kill turns the next WB slot into a bubble.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      wb_data_r        <= 32'd0;
      wb_write_addr_r  <= 5'd0;
      wb_we_r          <= 1'b0;
      wb_instruction_r <= 32'd0;
      wb_pc_r          <= 32'd0;
    end else if (stall_s || kill_i) begin
      wb_we_r          <= 1'b0;
      wb_instruction_r <= 32'd0;
    end else begin
      wb_data_r        <= (is_load_s && hit_s) ? load_format(word_s, funct3_s, tl_cache_addr_i[1:0])
                                               : tl_cache_addr_i;
      wb_write_addr_r  <= tl_write_addr_i;
      wb_we_r          <= tl_int_write_enable_i && !is_store_s;
      wb_instruction_r <= tl_instruction_i;
      wb_pc_r          <= tl_pc_i;
    end
  end

  assign mem_req_o             = mem_req_r;
  assign mem_we_o              = mem_we_r;
  assign mem_addr_o            = mem_addr_r;
  assign mem_wdata_o           = mem_wdata_r;
  assign mem_wstrb_o           = mem_wstrb_r;
  assign wb_data_o             = wb_data_r;
  assign wb_write_addr_o       = wb_write_addr_r;
  assign wb_int_write_enable_o = wb_we_r;
  assign wb_instruction_o      = wb_instruction_r;
  assign wb_pc_o               = wb_pc_r;

endmodule
